// File: rtl/fetch_unit_mc.sv
// Instruction-fetch stage: PC, tagged direct-mapped BTB + 2-bit BHT, req/ack imem
// interface with redirect draining, and a single registered IF/ID output slot.
module fetch_unit_mc #(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 16,
  parameter int              BP_ENTRIES = 8,
  parameter int              INST_BYTES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] actual_target_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              actual_taken_i,
  input  logic              wen_BTB_i,
  input  logic              wen_BHT_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              imem_ack_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [1:0]        prediction_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] predicted_target_o
);

  localparam int IDX_LSB = $clog2(INST_BYTES);
  localparam int IDX_W   = $clog2(BP_ENTRIES);
  localparam int TAG_W   = ADDR_W - IDX_LSB - IDX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic              btb_vld_q [BP_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q [BP_ENTRIES];
  logic [ADDR_W-1:0] btb_tgt_q [BP_ENTRIES];
  logic [1:0]        bht_q     [BP_ENTRIES];

  logic              free, capture;
  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, lk_taken;
  logic [1:0]        lk_ctr, up_ctr, up_ctr_nxt;
  logic [ADDR_W-1:0] lk_tgt, seq_pc;

  assign free = !inst_valid_o || !stall_i;

  // Reset gates the request so an in-flight transaction is abandoned immediately.
  always_comb begin
    imem_req_o = 1'b0;
    case (state_q)
      S_IDLE:  imem_req_o = free && !redirect_i;
      S_WAIT,
      S_DRAIN: imem_req_o = 1'b1;
      default: imem_req_o = 1'b0;
    endcase
    imem_req_o = imem_req_o && rst_i;
  end

  assign imem_addr_o = (state_q == S_IDLE) ? pc_q : req_addr_q;

  // Lookup follows the outstanding request address so a same-cycle ack in IDLE sees it.
  assign lk_idx   = imem_addr_o[IDX_LSB +: IDX_W];
  assign lk_tag   = imem_addr_o[ADDR_W-1 -: TAG_W];
  assign lk_hit   = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign lk_ctr   = bht_q[lk_idx];
  assign lk_taken = lk_ctr[1] && lk_hit;
  assign lk_tgt   = lk_hit ? btb_tgt_q[lk_idx] : '0;
  assign seq_pc   = imem_addr_o + ADDR_W'(INST_BYTES);

  assign capture = imem_req_o && imem_ack_i && !redirect_i && (state_q != S_DRAIN);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pc_d       = pc_q;
    case (state_q)
      S_IDLE: if (imem_req_o) begin
        req_addr_d = pc_q;
        if (!imem_ack_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack_i)      state_d = S_IDLE;
        else if (redirect_i) state_d = S_DRAIN;
      end
      S_DRAIN: if (imem_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (redirect_i)   pc_d = actual_target_i;
    else if (capture) pc_d = lk_taken ? lk_tgt : seq_pc;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Redirect kills the held instruction even under stall: it is wrong-path.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inst_valid_o       <= 1'b0;
      inst_o             <= '0;
      inst_pc_o          <= '0;
      prediction_o       <= '0;
      pred_taken_o       <= 1'b0;
      predicted_target_o <= '0;
    end else if (redirect_i) begin
      inst_valid_o <= 1'b0;
    end else if (capture) begin
      inst_valid_o       <= 1'b1;
      inst_o             <= imem_rdata_i;
      inst_pc_o          <= imem_addr_o;
      prediction_o       <= lk_ctr;
      pred_taken_o       <= lk_taken;
      predicted_target_o <= lk_tgt;
    end else if (inst_valid_o && !stall_i) begin
      inst_valid_o <= 1'b0;
    end
  end

  assign up_idx = upd_pc_i[IDX_LSB +: IDX_W];
  assign up_tag = upd_pc_i[ADDR_W-1 -: TAG_W];
  assign up_ctr = bht_q[up_idx];

  always_comb begin
    up_ctr_nxt = up_ctr;
    if (actual_taken_i && up_ctr != 2'b11)      up_ctr_nxt = up_ctr + 2'b01;
    else if (!actual_taken_i && up_ctr != 2'b00) up_ctr_nxt = up_ctr - 2'b01;
  end

  // Tag/target arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (wen_BTB_i) begin
      btb_tag_q[up_idx] <= up_tag;
      btb_tgt_q[up_idx] <= actual_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        btb_vld_q[i] <= 1'b0;
        bht_q[i]     <= 2'b01;
      end
    end else if (clr_i) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        btb_vld_q[i] <= 1'b0;
        bht_q[i]     <= 2'b01;
      end
    end else begin
      if (wen_BTB_i) btb_vld_q[up_idx] <= 1'b1;
      if (wen_BHT_i) bht_q[up_idx]     <= up_ctr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit_mc.sv
// Directed bench for fetch_unit_mc with a latency-programmable memory model.
module tb_fetch_unit_mc;
  logic        clk = 1'b0;
  logic        rst_n, clr, stall, redirect, actual_taken, wen_btb, wen_bht;
  logic [15:0] actual_target, upd_pc;
  logic        imem_req, imem_ack, inst_valid, pred_taken;
  logic [15:0] imem_addr, imem_rdata, inst, inst_pc, predicted_target;
  logic [1:0]  prediction;

  int checks = 0;
  int fails  = 0;
  int lat    = 0;
  logic [3:0] mem_cnt = '0;

  always #5 clk = ~clk;

  fetch_unit_mc dut (
    .clk_i(clk), .rst_i(rst_n), .clr_i(clr), .stall_i(stall), .redirect_i(redirect),
    .actual_target_i(actual_target), .upd_pc_i(upd_pc), .actual_taken_i(actual_taken),
    .wen_BTB_i(wen_btb), .wen_BHT_i(wen_bht),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .imem_ack_i(imem_ack), .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc),
    .prediction_o(prediction), .pred_taken_o(pred_taken), .predicted_target_o(predicted_target)
  );

  // Memory acks after the request has been held for lat cycles.
  assign imem_ack   = imem_req && (int'(mem_cnt) >= lat);
  assign imem_rdata = 16'hA000 + imem_addr;
  always @(posedge clk) mem_cnt <= (!imem_req || imem_ack) ? 4'd0 : mem_cnt + 4'd1;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_inst;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic redirect_to(input logic [15:0] a);
    redirect = 1'b1; actual_target = a;
    tick();
    redirect = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    logic ok;
    tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA000};
    tbl[2] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hA002};
    tbl[3] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hA004};
    tbl[4] = '{1'b1, 1'b0, 16'h0008, 1'b1, 16'h0006, 16'hA006};
    tbl[5] = '{1'b1, 1'b0, 16'h0008, 1'b1, 16'h0006, 16'hA006};
    tbl[6] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'hA006};
    tbl[7] = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0008, 16'hA008};

    rst_n = 1'b0; clr = 1'b0; stall = 1'b0; redirect = 1'b0; actual_taken = 1'b0;
    wen_btb = 1'b0; wen_bht = 1'b0; actual_target = '0; upd_pc = '0;
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_outs", {inst, inst_pc, prediction, pred_taken, predicted_target}, 0);
    chk("rst_more", {inst, predicted_target}, 0);
    rst_n = 1'b1;

    // Zero-wait streaming with a stall bubble.
    for (int i = 0; i < 8; i++) begin
      stall = tbl[i].stall;
      #1;
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].exp_req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_valid", i), inst_valid, tbl[i].exp_valid);
      chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].exp_pc);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].exp_inst);
      tick();
    end

    // Three-cycle memory with stall while the slot is occupied.
    lat = 3; stall = 1'b1; #1;
    chk("lat_stall_req", imem_req, 0);
    tick(); tick();
    chk("lat_hold_pc", inst_pc, 16'h000A);
    chk("lat_hold_inst", inst, 16'hA00A);
    stall = 1'b0; #1;
    chk("lat_req", {imem_req, imem_addr}, {1'b1, 16'h000C});
    tick();
    ok = 1'b1; n = 0;
    while (!inst_valid && n < 10) begin
      if (!imem_req || imem_addr !== 16'h000C) ok = 1'b0;
      tick(); n++;
    end
    chk("lat_timeout", inst_valid, 1);
    chk("lat_addr_stable", ok, 1);
    chk("lat_pc", inst_pc, 16'h000C);
    stall = 1'b1; #1;
    chk("lat_stall2_req", imem_req, 0);
    tick(); tick();
    chk("lat_hold2", {inst, inst_pc}, {16'hA00C, 16'h000C});
    stall = 1'b0; #1;
    chk("lat_next_addr", {imem_req, imem_addr}, {1'b1, 16'h000E});
    tick();
    lat = 0;
    tick();

    // Train entry for 0x0004 -> 0x0040, counter 01 -> 11.
    stall = 1'b1; upd_pc = 16'h0004; actual_target = 16'h0040; actual_taken = 1'b1;
    wen_btb = 1'b1; wen_bht = 1'b1;
    tick();
    wen_btb = 1'b0;
    tick();
    wen_bht = 1'b0; stall = 1'b0;
    redirect_to(16'h0004);
    chk("bp_req", {imem_req, imem_addr}, {1'b1, 16'h0004});
    tick();
    chk("bp_pc", inst_pc, 16'h0004);
    chk("bp_taken", pred_taken, 1);
    chk("bp_ctr", prediction, 2'b11);
    chk("bp_tgt", predicted_target, 16'h0040);
    chk("bp_next", imem_addr, 16'h0040);

    // Same index, different tag.
    redirect_to(16'h0014);
    tick();
    chk("tag_pc", inst_pc, 16'h0014);
    chk("tag_taken", pred_taken, 0);
    chk("tag_ctr", prediction, 2'b11);
    chk("tag_next", imem_addr, 16'h0016);

    // Redirect while a slow request is outstanding.
    lat = 3;
    tick();
    chk("wait_state", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0016, 1'b0});
    redirect_to(16'h0100);
    chk("drain_req", {imem_req, imem_addr}, {1'b1, 16'h0016});
    ok = 1'b1; n = 0;
    while (imem_addr !== 16'h0100 && n < 10) begin
      if (inst_valid) ok = 1'b0;
      tick(); n++;
    end
    chk("drain_timeout", imem_addr, 16'h0100);
    chk("drain_discard", {ok, inst_valid}, 2'b10);
    n = 0;
    while (!inst_valid && n < 10) begin tick(); n++; end
    chk("drain_fetch", {inst_valid, inst_pc, inst}, {1'b1, 16'h0100, 16'hA100});

    // Sequential wrap at the top of the address space.
    lat = 0;
    redirect_to(16'hFFFE);
    tick();
    chk("wrap_pc", inst_pc, 16'hFFFE);
    chk("wrap_next", imem_addr, 16'h0000);

    // Flush wins over a simultaneous counter update.
    stall = 1'b1; clr = 1'b1; wen_bht = 1'b1; upd_pc = 16'h0004; actual_taken = 1'b1;
    tick();
    clr = 1'b0; wen_bht = 1'b0; stall = 1'b0;
    redirect_to(16'h0004);
    tick();
    chk("clr_ctr", prediction, 2'b01);
    chk("clr_taken", pred_taken, 0);
    chk("clr_next", imem_addr, 16'h0006);

    // Asynchronous reset while waiting on memory.
    lat = 3;
    tick();
    chk("rw_wait", {imem_req, inst_valid}, 2'b10);
    #2 rst_n = 1'b0; #1;
    chk("rw_req", imem_req, 0);
    chk("rw_outs", {inst_valid, inst_pc}, 0);
    tick();
    rst_n = 1'b1; #1;
    chk("rw_pc", {imem_req, imem_addr}, {1'b1, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
